pc_strobe_seq: RTL and testbench

- Control sequencer sitting directly upstream of the two cascaded 8-bit register/counter chips (low byte, high byte) that form the 16-bit program counter.
- Turns single-cycle-clocked requests from the control unit (increment, jump, clear) into correctly ordered chip strobes: counter clock, counter enables, register clock, load and clear.
- Also supplies the jump target onto the chips' register inputs.

---
 rtl/pc_strobe_seq_pkg.sv | 23 ++
 rtl/pc_strobe_seq_if.sv | 34 +++
 rtl/pc_strobe_seq.sv | 137 +++++++++++++
 tb/tb_pc_strobe_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_strobe_seq_pkg.sv
// Shared types and constants for the program-counter strobe sequencer.
package pc_strobe_seq_pkg;

  localparam int PC_WIDTH      = 16;
  localparam int PC_CHIP_WIDTH = 8;

  localparam logic CCKEN_BAR_OFF = 1'b1;
  localparam logic RCKEN_BAR_OFF = 1'b1;
  localparam logic CLOAD_BAR_OFF = 1'b1;
  localparam logic CCLR_BAR_OFF  = 1'b1;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    INC_SETUP,
    INC_CLK,
    LD_SETUP,
    LD_RCK,
    LD_XFER,
    DONE
  } state_t;

endpackage

// File: rtl/pc_strobe_seq_if.sv
// Request/ack handshake from the control unit plus strobes and data to the PC counter chips.
interface pc_strobe_seq_if #(
  parameter int WIDTH = 16
);
  logic             inc_req;
  logic             jump_req;
  logic             clr_req;
  logic [WIDTH-1:0] jump_addr;
  logic             rco_lo_bar;

  logic             ack;
  logic             busy;
  logic             cck;
  logic             ccken_lo;
  logic             ccken_hi;
  logic             ccken_bar;
  logic             rck;
  logic             rcken_bar;
  logic             cload_bar;
  logic             cclr_bar;
  logic [WIDTH-1:0] inq;

  modport master (
    output inc_req, jump_req, clr_req, jump_addr, rco_lo_bar,
    input  ack, busy, cck, ccken_lo, ccken_hi, ccken_bar,
           rck, rcken_bar, cload_bar, cclr_bar, inq
  );

  modport slave (
    input  inc_req, jump_req, clr_req, jump_addr, rco_lo_bar,
    output ack, busy, cck, ccken_lo, ccken_hi, ccken_bar,
           rck, rcken_bar, cload_bar, cclr_bar, inq
  );
endinterface

// File: rtl/pc_strobe_seq.sv
// Sequences increment/jump/clear requests into ordered strobes for two cascaded
// 8-bit register/counter chips forming the 16-bit program counter.
module pc_strobe_seq
  import pc_strobe_seq_pkg::*;
#(
  parameter int WIDTH      = PC_WIDTH,
  parameter int CHIP_WIDTH = PC_CHIP_WIDTH
) (
  input logic            clk,
  input logic            reset,
  pc_strobe_seq_if.slave bus
);

  state_t state, state_next;
  logic   from_rst;

  logic cck_q, ccken_lo_q, ccken_hi_q, ccken_bar_q;
  logic rck_q, rcken_bar_q, cload_bar_q, cclr_bar_q;
  logic ack_q, busy_q;
  logic [CHIP_WIDTH-1:0] inq_lo_q, inq_hi_q;

  logic cck_d, ccken_lo_d, ccken_hi_d, ccken_bar_d;
  logic rck_d, rcken_bar_d, cload_bar_d, cclr_bar_d;
  logic ack_d, busy_d;
  logic load_jump;

  always_comb begin
    state_next = state;
    unique case (state)
      CLR:       state_next = DONE;
      IDLE: begin
        if (bus.clr_req)       state_next = CLR;
        else if (bus.jump_req) state_next = LD_SETUP;
        else if (bus.inc_req)  state_next = INC_SETUP;
      end
      INC_SETUP: state_next = INC_CLK;
      INC_CLK:   state_next = DONE;
      LD_SETUP:  state_next = LD_RCK;
      LD_RCK:    state_next = LD_XFER;
      LD_XFER:   state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = CLR;
    endcase
  end

  // Outputs are decoded from the state being entered and registered, so each
  // strobe level is valid for exactly the cycle spent in that state.
  always_comb begin
    cck_d       = 1'b0;
    ccken_lo_d  = 1'b0;
    ccken_hi_d  = 1'b0;
    ccken_bar_d = CCKEN_BAR_OFF;
    rck_d       = 1'b0;
    rcken_bar_d = RCKEN_BAR_OFF;
    cload_bar_d = CLOAD_BAR_OFF;
    cclr_bar_d  = CCLR_BAR_OFF;
    ack_d       = 1'b0;
    busy_d      = (state_next != IDLE);
    load_jump   = (state == IDLE) && (state_next == LD_SETUP);

    unique case (state_next)
      INC_SETUP: begin
        ccken_bar_d = 1'b0;
        ccken_lo_d  = 1'b1;
        ccken_hi_d  = ~bus.rco_lo_bar;
      end
      INC_CLK: begin
        ccken_bar_d = 1'b0;
        ccken_lo_d  = 1'b1;
        ccken_hi_d  = ccken_hi_q;
        cck_d       = 1'b1;
      end
      LD_SETUP:  rcken_bar_d = 1'b0;
      LD_RCK: begin
        rcken_bar_d = 1'b0;
        rck_d       = 1'b1;
      end
      LD_XFER:   cload_bar_d = 1'b0;
      CLR:       cclr_bar_d  = 1'b0;
      DONE:      ack_d       = ~from_rst;
      default: ;
    endcase

    // Reset parks the FSM in CLR with the clear strobe held inactive, so the
    // post-reset clear pulse lands in the following DONE cycle instead.
    if ((state == CLR) && from_rst) cclr_bar_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CLR;
      from_rst    <= 1'b1;
      cck_q       <= 1'b0;
      ccken_lo_q  <= 1'b0;
      ccken_hi_q  <= 1'b0;
      ccken_bar_q <= CCKEN_BAR_OFF;
      rck_q       <= 1'b0;
      rcken_bar_q <= RCKEN_BAR_OFF;
      cload_bar_q <= CLOAD_BAR_OFF;
      cclr_bar_q  <= CCLR_BAR_OFF;
      ack_q       <= 1'b0;
      busy_q      <= 1'b1;
      inq_lo_q    <= '0;
      inq_hi_q    <= '0;
    end else begin
      state       <= state_next;
      from_rst    <= 1'b0;
      cck_q       <= cck_d;
      ccken_lo_q  <= ccken_lo_d;
      ccken_hi_q  <= ccken_hi_d;
      ccken_bar_q <= ccken_bar_d;
      rck_q       <= rck_d;
      rcken_bar_q <= rcken_bar_d;
      cload_bar_q <= cload_bar_d;
      cclr_bar_q  <= cclr_bar_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      if (load_jump) begin
        inq_lo_q <= bus.jump_addr[CHIP_WIDTH-1:0];
        inq_hi_q <= bus.jump_addr[WIDTH-1:CHIP_WIDTH];
      end
    end
  end

  assign bus.cck       = cck_q;
  assign bus.ccken_lo  = ccken_lo_q;
  assign bus.ccken_hi  = ccken_hi_q;
  assign bus.ccken_bar = ccken_bar_q;
  assign bus.rck       = rck_q;
  assign bus.rcken_bar = rcken_bar_q;
  assign bus.cload_bar = cload_bar_q;
  assign bus.cclr_bar  = cclr_bar_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.inq       = {inq_hi_q, inq_lo_q};

endmodule

// File: tb/tb_pc_strobe_seq.sv
// Directed bench for pc_strobe_seq with a behavioural model of the two counter chips.
module tb_pc_strobe_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_strobe_seq_if #(.WIDTH(16)) bus();

  pc_strobe_seq #(.WIDTH(16), .CHIP_WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Counter chip model state, updated on the falling clock edge.
  logic [15:0] pc_m   = 16'h5A5A;
  logic [15:0] rreg_m = 16'h0000;
  logic [7:0]  lo_t, hi_t;
  logic cck_p = 1'b0, rck_p = 1'b0, ccken_bar_p = 1'b1, lo_p = 1'b0, hi_p = 1'b0, rcken_bar_p = 1'b1;
  int   viol = 0;
  int   cload_cnt = 0;

  assign bus.rco_lo_bar = (pc_m[7:0] != 8'hFF);

  always @(negedge clk) begin
    if (bus.cck && !cck_p) begin
      if (bus.ccken_bar != ccken_bar_p || bus.ccken_lo != lo_p || bus.ccken_hi != hi_p) viol++;
      if (!bus.ccken_bar) begin
        lo_t = pc_m[7:0];
        hi_t = pc_m[15:8];
        if (bus.ccken_lo) lo_t = lo_t + 8'd1;
        if (bus.ccken_hi) hi_t = hi_t + 8'd1;
        pc_m = {hi_t, lo_t};
      end
    end
    if (bus.rck && !rck_p) begin
      if (bus.rcken_bar != rcken_bar_p) viol++;
      if (!bus.rcken_bar) rreg_m = bus.inq;
    end
    if (!bus.cload_bar) begin
      pc_m = rreg_m;
      cload_cnt++;
    end
    if (!bus.cclr_bar) pc_m = 16'h0000;
    if (!bus.cload_bar && !bus.cclr_bar) viol++;
    if (!bus.cclr_bar && bus.cck) viol++;
    cck_p       = bus.cck;
    rck_p       = bus.rck;
    ccken_bar_p = bus.ccken_bar;
    lo_p        = bus.ccken_lo;
    hi_p        = bus.ccken_hi;
    rcken_bar_p = bus.rcken_bar;
  end

  // Observations of the most recent operation.
  int   lat, n_cck, n_rck, n_cload, n_cclr;
  logic hi_seen, rck_ok, ack_after;

  task automatic wait_ack();
    lat = -1; n_cck = 0; n_rck = 0; n_cload = 0; n_cclr = 0;
    hi_seen = 1'b0; rck_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.cck) begin n_cck++; hi_seen = bus.ccken_hi; end
      if (bus.rck) begin n_rck++; if (bus.rcken_bar !== 1'b0) rck_ok = 1'b0; end
      if (!bus.cload_bar) n_cload++;
      if (!bus.cclr_bar) n_cclr++;
      if (bus.ack) begin lat = c; break; end
    end
  endtask

  task automatic run_op(input int kind, input logic [15:0] addr);
    bus.jump_addr = addr;
    bus.clr_req   = (kind == 0);
    bus.jump_req  = (kind == 1);
    bus.inc_req   = (kind == 2);
    wait_ack();
    bus.clr_req = 1'b0; bus.jump_req = 1'b0; bus.inc_req = 1'b0;
    @(posedge clk); #1;
    ack_after = bus.ack;
  endtask

  task automatic test_reset();
    logic [9:0] v;
    int cl = 0, ak = 0;
    logic b1 = 1'b0, b2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    v = {bus.cck, bus.ccken_lo, bus.ccken_hi, bus.ccken_bar, bus.rck,
         bus.rcken_bar, bus.cload_bar, bus.cclr_bar, bus.ack, bus.busy};
    total++; if (v !== 10'b0001011101) begin bad++; $display("FAIL reset_outputs: got %b expected %b", v, 10'b0001011101); end
    total++; if (bus.inq !== 16'h0000) begin bad++; $display("FAIL reset_inq: got %h expected 0000", bus.inq); end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (!bus.cclr_bar) cl++;
      if (bus.ack) ak++;
      if (k == 1) b1 = bus.busy;
      if (k == 2) b2 = bus.busy;
    end
    total++; if (cl !== 1) begin bad++; $display("FAIL reset_cclr_len: got %0d expected 1", cl); end
    total++; if (ak !== 0) begin bad++; $display("FAIL reset_no_ack: got %0d expected 0", ak); end
    total++; if (b1 !== 1'b1 || b2 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b%b expected 10", b1, b2); end
    total++; if (pc_m !== 16'h0000) begin bad++; $display("FAIL reset_pc: got %h expected 0000", pc_m); end
  endtask

  task automatic test_inc();
    run_op(1, 16'h00FE);
    total++; if (pc_m !== 16'h00FE) begin bad++; $display("FAIL inc_preload: got %h expected 00fe", pc_m); end
    run_op(2, 16'h0000);
    total++; if (lat !== 3) begin bad++; $display("FAIL inc_latency: got %0d expected 3", lat); end
    total++; if (n_cck !== 1) begin bad++; $display("FAIL inc_cck_count: got %0d expected 1", n_cck); end
    total++; if (hi_seen !== 1'b0) begin bad++; $display("FAIL inc_no_carry_hi: got %b expected 0", hi_seen); end
    total++; if (pc_m !== 16'h00FF) begin bad++; $display("FAIL inc_pc_00ff: got %h expected 00ff", pc_m); end
    total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL inc_ack_pulse: got %b expected 0", ack_after); end
    run_op(2, 16'h0000);
    total++; if (hi_seen !== 1'b1) begin bad++; $display("FAIL inc_carry_hi: got %b expected 1", hi_seen); end
    total++; if (pc_m !== 16'h0100) begin bad++; $display("FAIL inc_pc_0100: got %h expected 0100", pc_m); end
  endtask

  task automatic test_wrap();
    run_op(1, 16'hFFFF);
    run_op(2, 16'h0000);
    total++; if (hi_seen !== 1'b1) begin bad++; $display("FAIL wrap_carry_hi: got %b expected 1", hi_seen); end
    total++; if (pc_m !== 16'h0000) begin bad++; $display("FAIL wrap_pc: got %h expected 0000", pc_m); end
  endtask

  task automatic test_jump();
    run_op(1, 16'hA55A);
    total++; if (lat !== 4) begin bad++; $display("FAIL jump_latency: got %0d expected 4", lat); end
    total++; if (bus.inq !== 16'hA55A) begin bad++; $display("FAIL jump_inq: got %h expected a55a", bus.inq); end
    total++; if (n_rck !== 1 || rck_ok !== 1'b1) begin bad++; $display("FAIL jump_rck: got n=%0d ok=%b expected n=1 ok=1", n_rck, rck_ok); end
    total++; if (n_cload !== 1) begin bad++; $display("FAIL jump_cload_len: got %0d expected 1", n_cload); end
    total++; if (pc_m !== 16'hA55A) begin bad++; $display("FAIL jump_pc: got %h expected a55a", pc_m); end
  endtask

  task automatic test_priority();
    run_op(1, 16'h1234);
    total++; if (pc_m !== 16'h1234) begin bad++; $display("FAIL prio_preload: got %h expected 1234", pc_m); end
    bus.jump_addr = 16'h0F0F;
    bus.clr_req = 1'b1; bus.jump_req = 1'b1; bus.inc_req = 1'b1;
    wait_ack();
    total++; if (lat !== 2 || n_cclr !== 1) begin bad++; $display("FAIL prio_clear_first: got lat=%0d cclr=%0d expected lat=2 cclr=1", lat, n_cclr); end
    total++; if (pc_m !== 16'h0000) begin bad++; $display("FAIL prio_clear_pc: got %h expected 0000", pc_m); end
    bus.clr_req = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL prio_clear_ack_pulse: got %b expected 0", bus.ack); end
    wait_ack();
    total++; if (lat !== 4 || n_cload !== 1) begin bad++; $display("FAIL prio_jump_second: got lat=%0d cload=%0d expected lat=4 cload=1", lat, n_cload); end
    total++; if (pc_m !== 16'h0F0F) begin bad++; $display("FAIL prio_jump_pc: got %h expected 0f0f", pc_m); end
    bus.jump_req = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ack !== 1'b0) begin bad++; $display("FAIL prio_jump_ack_pulse: got %b expected 0", bus.ack); end
    wait_ack();
    total++; if (lat !== 3 || n_cck !== 1) begin bad++; $display("FAIL prio_inc_third: got lat=%0d cck=%0d expected lat=3 cck=1", lat, n_cck); end
    total++; if (pc_m !== 16'h0F10) begin bad++; $display("FAIL prio_inc_pc: got %h expected 0f10", pc_m); end
    bus.inc_req = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.ack !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL prio_idle_after: got ack=%b busy=%b expected 0 0", bus.ack, bus.busy); end
  endtask

  task automatic test_reset_mid();
    int   snap;
    logic seen = 1'b0;
    bus.jump_addr = 16'h3C3C;
    bus.jump_req  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (bus.rck) begin seen = 1'b1; break; end
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL midrst_rck_seen: got %b expected 1", seen); end
    reset = 1'b1;
    bus.jump_req = 1'b0;
    #1;
    total++; if (bus.rck !== 1'b0 || bus.rcken_bar !== 1'b1) begin bad++; $display("FAIL midrst_strobes: got rck=%b rcken_bar=%b expected 0 1", bus.rck, bus.rcken_bar); end
    snap = cload_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (pc_m !== 16'h0000) begin bad++; $display("FAIL midrst_pc: got %h expected 0000", pc_m); end
    total++; if (cload_cnt !== snap) begin bad++; $display("FAIL midrst_no_cload: got %0d expected %0d", cload_cnt, snap); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_strobe_rules();
    total++; if (viol !== 0) begin bad++; $display("FAIL strobe_rules: got %0d violations expected 0", viol); end
  endtask

  initial begin
    bus.inc_req   = 1'b0;
    bus.jump_req  = 1'b0;
    bus.clr_req   = 1'b0;
    bus.jump_addr = 16'h0000;
    test_reset();
    test_inc();
    test_wrap();
    test_jump();
    test_priority();
    test_reset_mid();
    test_strobe_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
